// File: rtl/serial_frame_stager_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_stager_if
// Summary  : Word-side handshakes and link-side frame buses of the stager
// Revision : 1.0  initial release
// ============================================================================
interface serial_frame_stager_if #(
  parameter int DATA_WIDTH = 171,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic [WORD_WIDTH-1:0] tx_word;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [WORD_WIDTH-1:0] rx_word;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] link_parallel_in;
  logic [DATA_WIDTH-1:0] link_parallel_out;
  logic                  link_cs;
  logic [CNT_WIDTH-1:0]  tx_underrun_cnt;
  logic [CNT_WIDTH-1:0]  rx_overflow_cnt;

  // master: the stager itself; slave: word producer/consumer plus link engine
  modport master (
    input  tx_word, tx_valid, rx_ready, link_parallel_out, link_cs,
    output tx_ready, rx_word, rx_valid, link_parallel_in,
           tx_underrun_cnt, rx_overflow_cnt
  );

  modport slave (
    output tx_word, tx_valid, rx_ready, link_parallel_out, link_cs,
    input  tx_ready, rx_word, rx_valid, link_parallel_in,
           tx_underrun_cnt, rx_overflow_cnt
  );
endinterface
`default_nettype wire

// File: rtl/serial_frame_stager.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_stager
// Summary  : Packs tx words into link frames, unpacks received frames to words
// Revision : 1.0  initial release
// ============================================================================
module serial_frame_stager #(
  parameter int                    DATA_WIDTH   = 171,
  parameter int                    WORD_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '0,
  parameter int                    CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_frame_stager_if.master bus
);
  localparam int c_WPF    = (DATA_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int c_FLAT_W = c_WPF * WORD_WIDTH;
  localparam int c_PAD    = c_FLAT_W - DATA_WIDTH;
  localparam int c_IDX_W  = (c_WPF > 1) ? $clog2(c_WPF) : 1;
  localparam logic [c_IDX_W-1:0]   c_LAST    = c_IDX_W'(c_WPF - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  typedef enum logic [0:0] {TX_FILL = 1'b0, TX_FULL = 1'b1} tx_state_t;
  typedef enum logic [0:0] {RX_IDLE = 1'b0, RX_SEND = 1'b1} rx_state_t;

  tx_state_t             r_tx_state;
  logic [c_IDX_W-1:0]    r_count;
  logic [WORD_WIDTH-1:0] r_tx_words [c_WPF];
  logic [DATA_WIDTH-1:0] r_link_in;
  logic [CNT_WIDTH-1:0]  r_underrun;

  rx_state_t             r_rx_state;
  logic [c_IDX_W-1:0]    r_idx;
  logic [WORD_WIDTH-1:0] r_rx_buf [c_WPF];
  logic [WORD_WIDTH-1:0] r_rx_word;
  logic                  r_rx_valid;
  logic [CNT_WIDTH-1:0]  r_overflow;

  logic                  r_cs_q;

  wire  [c_FLAT_W-1:0]   w_tx_flat;
  wire  [WORD_WIDTH-1:0] w_rx_words [c_WPF];
  logic [c_FLAT_W-1:0]   w_rx_flat;
  logic [DATA_WIDTH-1:0] w_tx_frame;
  logic                  w_bnd;
  logic                  w_tx_fire;
  logic                  w_rx_hs;
  logic                  w_rx_last;
  logic                  w_rx_capture;
  logic [c_IDX_W-1:0]    w_idx_nxt;

  // Frames are handled as WPF whole words; the last word's low pad bits fall off the bottom.
  assign w_rx_flat  = c_FLAT_W'(bus.link_parallel_out) << c_PAD;
  assign w_tx_frame = w_tx_flat[c_FLAT_W-1 -: DATA_WIDTH];

  generate
    for (genvar k = 0; k < c_WPF; k++) begin : g_word
      assign w_tx_flat[c_FLAT_W-1-k*WORD_WIDTH -: WORD_WIDTH] = r_tx_words[k];
      assign w_rx_words[k] = w_rx_flat[c_FLAT_W-1-k*WORD_WIDTH -: WORD_WIDTH];
    end
    if (c_PAD > 0) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^w_tx_flat[c_PAD-1:0];
    end
  endgenerate

  assign w_bnd        = bus.link_cs & ~r_cs_q;
  assign w_tx_fire    = bus.tx_valid & (r_tx_state == TX_FILL);
  assign w_rx_hs      = r_rx_valid & bus.rx_ready;
  assign w_rx_last    = w_rx_hs & (r_idx == c_LAST);
  assign w_rx_capture = w_bnd & ((r_rx_state == RX_IDLE) | w_rx_last);
  assign w_idx_nxt    = r_idx + c_IDX_W'(1);

  // Reset value 1 keeps the link's post-reset chip-select high from looking like a frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cs_q <= 1'b1;
    else        r_cs_q <= bus.link_cs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_FILL;
      r_count    <= '0;
      for (int k = 0; k < c_WPF; k++) r_tx_words[k] <= '0;
      r_link_in  <= IDLE_PATTERN;
      r_underrun <= '0;
    end else begin
      if (w_tx_fire) begin
        r_tx_words[r_count] <= bus.tx_word;
        if (r_count == c_LAST) r_tx_state <= TX_FULL;
        else                   r_count    <= r_count + c_IDX_W'(1);
      end
      // A boundary only swaps a frame that was already FULL before this cycle.
      if (w_bnd) begin
        if (r_tx_state == TX_FULL) begin
          r_link_in  <= w_tx_frame;
          r_count    <= '0;
          r_tx_state <= TX_FILL;
        end else begin
          r_link_in <= IDLE_PATTERN;
          if (r_underrun != c_CNT_MAX) r_underrun <= r_underrun + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_idx      <= '0;
      for (int k = 0; k < c_WPF; k++) r_rx_buf[k] <= '0;
      r_rx_word  <= '0;
      r_rx_valid <= 1'b0;
      r_overflow <= '0;
    end else if (w_rx_capture) begin
      for (int k = 0; k < c_WPF; k++) r_rx_buf[k] <= w_rx_words[k];
      r_idx      <= '0;
      r_rx_word  <= w_rx_words[0];
      r_rx_valid <= 1'b1;
      r_rx_state <= RX_SEND;
    end else if (r_rx_state == RX_SEND) begin
      if (w_bnd && (r_overflow != c_CNT_MAX)) r_overflow <= r_overflow + CNT_WIDTH'(1);
      if (w_rx_hs) begin
        if (r_idx == c_LAST) begin
          r_rx_state <= RX_IDLE;
          r_rx_valid <= 1'b0;
        end else begin
          r_idx     <= w_idx_nxt;
          r_rx_word <= r_rx_buf[w_idx_nxt];
        end
      end
    end
  end

  assign bus.tx_ready         = (r_tx_state == TX_FILL);
  assign bus.link_parallel_in = r_link_in;
  assign bus.tx_underrun_cnt  = r_underrun;
  assign bus.rx_word          = r_rx_word;
  assign bus.rx_valid         = r_rx_valid;
  assign bus.rx_overflow_cnt  = r_overflow;

endmodule
`default_nettype wire
